// File: rtl/cfg_bank_writer.sv
// cfg_bank_writer: single initiator for the eight-entry config_reg bank.
// Takes host write commands over valid/ready, optionally reads each write back
// to confirm it, and can restore all eight registers to their defaults with
// read-back confirmation. Mismatches are counted and the last bad address kept.
module cfg_bank_writer #(
  parameter logic [15:0] DEF_ADC0  = 16'hFFFF,
  parameter logic [15:0] DEF_ADC1  = 16'h0000,
  parameter logic [15:0] DEF_TEMP0 = 16'h0000,
  parameter logic [15:0] DEF_TEMP1 = 16'h0000,
  parameter logic [15:0] DEF_ATEST = 16'hABCD,
  parameter logic [15:0] DEF_DTEST = 16'h0000,
  parameter logic [15:0] DEF_GAIN  = 16'h0000,
  parameter logic [15:0] DEF_DCFG  = 16'h0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  input  logic        cmd_verify,
  input  logic        init_start,
  output logic        bank_write,
  output logic [2:0]  bank_addr,
  output logic [15:0] bank_data_in,
  input  logic [15:0] bank_data_out,
  output logic        busy,
  output logic        resp_valid,
  output logic        resp_err,
  output logic        init_done,
  output logic [7:0]  err_count,
  output logic [2:0]  err_addr
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_VERIFY  = 3'd2,
    ST_INIT_WR = 3'd3,
    ST_INIT_VF = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  // Latched target of the current write. These registers drive the bank
  // address/data directly, so in IDLE the bank sees the last driven values.
  logic [2:0]  r_addr;
  logic [15:0] r_data;
  logic        r_verify;
  logic [2:0]  r_idx;

  logic        r_resp_valid;
  logic        r_resp_err;
  logic        r_init_done;
  logic [7:0]  r_err_count;
  logic [2:0]  r_err_addr;

  logic        w_idle;
  logic        w_cmd_ready;
  logic        w_accept;
  logic        w_init_go;
  logic        w_check;
  logic        w_mismatch;
  logic        w_last;
  logic [2:0]  w_idx_inc;
  logic        w_bank_write;
  logic        w_busy;

  // Default value of each bank register, indexed by address.
  function automatic logic [15:0] def_value(input logic [2:0] idx);
    logic [15:0] v;
    case (idx)
      3'd0:    v = DEF_ADC0;
      3'd1:    v = DEF_ADC1;
      3'd2:    v = DEF_TEMP0;
      3'd3:    v = DEF_TEMP1;
      3'd4:    v = DEF_ATEST;
      3'd5:    v = DEF_DTEST;
      3'd6:    v = DEF_GAIN;
      default: v = DEF_DCFG;
    endcase
    return v;
  endfunction

  assign w_idle      = (r_state == ST_IDLE);
  // Held low while reset is asserted so the host never sees a ready
  // that the held-in-reset state machine could not honour.
  assign w_cmd_ready = reset && w_idle && !init_start;
  assign w_accept    = cmd_valid && w_cmd_ready;
  // A restore request wins over a simultaneous host command.
  assign w_init_go   = w_idle && init_start;
  assign w_check     = (r_state == ST_VERIFY) || (r_state == ST_INIT_VF);
  // Both VERIFY and INIT_VF compare against the value just written, which
  // is still sitting in r_data.
  assign w_mismatch  = (bank_data_out != r_data);
  assign w_last      = (r_idx == 3'd7);
  assign w_idx_inc   = r_idx + 3'd1;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (init_start) begin
          w_state_next = ST_INIT_WR;
        end else if (w_accept) begin
          w_state_next = ST_WRITE;
        end
      end
      ST_WRITE:   w_state_next = r_verify ? ST_VERIFY : ST_IDLE;
      ST_VERIFY:  w_state_next = ST_IDLE;
      ST_INIT_WR: w_state_next = ST_INIT_VF;
      ST_INIT_VF: w_state_next = w_last ? ST_IDLE : ST_INIT_WR;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs; derived from the state register so reset clears
  // them at once.
  always_comb begin
    w_bank_write = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      ST_IDLE:    w_busy       = 1'b0;
      ST_WRITE:   w_bank_write = 1'b1;
      ST_INIT_WR: w_bank_write = 1'b1;
      default:    w_bank_write = 1'b0;
    endcase
  end

  // Latch the command or step the restore index and its default value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr   <= 3'd0;
      r_data   <= 16'h0000;
      r_verify <= 1'b0;
      r_idx    <= 3'd0;
    end else if (w_init_go) begin
      r_idx    <= 3'd0;
      r_addr   <= 3'd0;
      r_data   <= def_value(3'd0);
    end else if (w_accept) begin
      r_addr   <= cmd_addr;
      r_data   <= cmd_data;
      r_verify <= cmd_verify;
    end else if (r_state == ST_INIT_VF) begin
      if (w_last) begin
        r_idx <= 3'd0;
      end else begin
        r_idx  <= w_idx_inc;
        r_addr <= w_idx_inc;
        r_data <= def_value(w_idx_inc);
      end
    end
  end

  // One-cycle completion pulses; the restore sequence never answers the host.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_init_done  <= 1'b0;
    end else begin
      r_resp_valid <= ((r_state == ST_WRITE) && !r_verify) || (r_state == ST_VERIFY);
      r_resp_err   <= (r_state == ST_VERIFY) && w_mismatch;
      r_init_done  <= (r_state == ST_INIT_VF) && w_last;
    end
  end

  // Mismatch bookkeeping shared by host verifies and the restore sequence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_count <= 8'd0;
      r_err_addr  <= 3'd0;
    end else if (w_check && w_mismatch) begin
      if (r_err_count != 8'hFF) begin
        r_err_count <= r_err_count + 8'd1;
      end
      r_err_addr <= r_addr;
    end
  end

  assign cmd_ready    = w_cmd_ready;
  assign bank_write   = w_bank_write;
  assign busy         = w_busy;
  assign bank_addr    = r_addr;
  assign bank_data_in = r_data;
  assign resp_valid   = r_resp_valid;
  assign resp_err     = r_resp_err;
  assign init_done    = r_init_done;
  assign err_count    = r_err_count;
  assign err_addr     = r_err_addr;

endmodule
